// File: rtl/uart_wb_bridge.sv
// uart_wb_bridge: ASCII-hex command bridge from a byte UART to a 32-bit
// Wishbone master. Frames look like 'L' + 24 hex digits (cmd, addr, data)
// and each one is answered with 'S' + 24 hex digits (status, addr, data) + LF.
module uart_wb_bridge (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_byte_available,
  input  logic [7:0]  rx_byte,
  input  logic        tx_ready,
  output logic [7:0]  tx_byte,
  output logic        tx_byte_en,
  output logic        tx_finished,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i
);

  localparam logic [7:0] ChStart = 8'h4C;  // 'L'
  localparam logic [7:0] ChResp  = 8'h53;  // 'S'
  localparam logic [7:0] ChLf    = 8'h0A;

  typedef enum logic       {P_IDLE, P_COLLECT}               p_state_e;
  typedef enum logic [1:0] {M_IDLE, M_BUS, M_RESP}           m_state_e;
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_FIN}    s_state_e;

  // Uppercase ASCII for one nibble.
  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

  // ---------------------------------------------------------------- parser
  p_state_e    p_state_q;
  logic        rx_prev_q;
  logic [4:0]  digit_cnt_q;
  logic [95:0] frame_q;
  logic        cmd_ready_q;

  logic       rx_edge;
  logic       hex_vld;
  logic [3:0] hex_nib;

  assign rx_edge = rx_byte_available & ~rx_prev_q;

  // Classify the incoming byte as a hex digit and decode its value.
  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    hex_vld = 1'b0;
    hex_nib = 4'h0;
    if (rx_byte >= 8'h30 && rx_byte <= 8'h39) begin
      hex_vld = 1'b1;
      hex_nib = rx_byte[3:0];
    end else if ((rx_byte >= 8'h41 && rx_byte <= 8'h46) ||
                 (rx_byte >= 8'h61 && rx_byte <= 8'h66)) begin
      hex_vld = 1'b1;
      hex_nib = rx_byte[3:0] + 4'd9;
    end
  end

  // Frame parser: one byte per rising edge of the strobe, 24 digits shifted in MSB first.
  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // register samples the values from before the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_state_q   <= P_IDLE;
      rx_prev_q   <= 1'b0;
      digit_cnt_q <= '0;
      frame_q     <= '0;
      cmd_ready_q <= 1'b0;
    end else begin
      rx_prev_q   <= rx_byte_available;
      cmd_ready_q <= 1'b0;
      if (rx_edge) begin
        case (p_state_q)
          P_IDLE: begin
            if (rx_byte == ChStart) begin
              p_state_q   <= P_COLLECT;
              digit_cnt_q <= '0;
            end
          end
          P_COLLECT: begin
            if (hex_vld) begin
              frame_q <= {frame_q[91:0], hex_nib};
              if (digit_cnt_q == 5'd23) begin
                cmd_ready_q <= 1'b1;
                p_state_q   <= P_IDLE;
              end else begin
                digit_cnt_q <= digit_cnt_q + 5'd1;
              end
            end else if (rx_byte == ChStart) begin
              digit_cnt_q <= '0;
            end else begin
              p_state_q <= P_IDLE;
            end
          end
          default: p_state_q <= P_IDLE;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------- master
  m_state_e    m_state_q;
  logic        cyc_q;
  logic        we_q;
  logic [3:0]  sel_q;
  logic [31:0] adr_q;
  logic [31:0] dat_q;
  logic [7:0]  timer_q;
  logic [31:0] cmd_q;
  logic [31:0] rsp_status_q;
  logic [31:0] rsp_adr_q;
  logic [31:0] rsp_data_q;

  s_state_e    s_state_q;
  logic        handoff;

  assign handoff = (m_state_q == M_RESP) && (s_state_q == S_IDLE);

  // Bus master: decode the command, run at most one Wishbone cycle, build the response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_state_q    <= M_IDLE;
      cyc_q        <= 1'b0;
      we_q         <= 1'b0;
      sel_q        <= 4'h0;
      adr_q        <= '0;
      dat_q        <= '0;
      timer_q      <= '0;
      cmd_q        <= '0;
      rsp_status_q <= '0;
      rsp_adr_q    <= '0;
      rsp_data_q   <= '0;
    end else begin
      case (m_state_q)
        M_IDLE: begin
          if (cmd_ready_q) begin
            cmd_q     <= frame_q[95:64];
            rsp_adr_q <= frame_q[63:32];
            if (frame_q[67:64] == 4'd1 || frame_q[67:64] == 4'd2) begin
              cyc_q     <= 1'b1;
              we_q      <= (frame_q[67:64] == 4'd1);
              sel_q     <= 4'hF;
              adr_q     <= frame_q[63:32];
              dat_q     <= frame_q[31:0];
              timer_q   <= '0;
              m_state_q <= M_BUS;
            end else begin
              rsp_status_q <= ~frame_q[95:64];
              rsp_data_q   <= '0;
              m_state_q    <= M_RESP;
            end
          end
        end
        M_BUS: begin
          if (wbm_ack_i) begin
            cyc_q        <= 1'b0;
            we_q         <= 1'b0;
            sel_q        <= 4'h0;
            rsp_status_q <= ~cmd_q;
            rsp_data_q   <= we_q ? dat_q : wbm_dat_i;
            m_state_q    <= M_RESP;
          end else if (timer_q == 8'hFF) begin
            cyc_q        <= 1'b0;
            we_q         <= 1'b0;
            sel_q        <= 4'h0;
            rsp_status_q <= '0;
            rsp_data_q   <= '0;
            m_state_q    <= M_RESP;
          end else begin
            timer_q <= timer_q + 8'd1;
          end
        end
        M_RESP: begin
          if (handoff) m_state_q <= M_IDLE;
        end
        default: m_state_q <= M_IDLE;
      endcase
    end
  end

  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;

  // ------------------------------------------------------------ serializer
  logic [4:0]  s_idx_q;
  logic [95:0] s_frame_q;
  logic [7:0]  tx_byte_q;
  logic        tx_en_q;
  logic        tx_fin_q;

  // Serializer: 'S', 24 digits, LF; one byte per tx_ready sample, then a gap cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_state_q <= S_IDLE;
      s_idx_q   <= '0;
      s_frame_q <= '0;
      tx_byte_q <= '0;
      tx_en_q   <= 1'b0;
      tx_fin_q  <= 1'b0;
    end else begin
      tx_en_q  <= 1'b0;
      tx_fin_q <= 1'b0;
      case (s_state_q)
        S_IDLE: begin
          if (handoff) begin
            s_frame_q <= {rsp_status_q, rsp_adr_q, rsp_data_q};
            s_idx_q   <= '0;
            s_state_q <= S_SEND;
          end
        end
        S_SEND: begin
          if (tx_ready) begin
            tx_en_q <= 1'b1;
            if (s_idx_q == 5'd0) begin
              tx_byte_q <= ChResp;
            end else if (s_idx_q == 5'd25) begin
              tx_byte_q <= ChLf;
            end else begin
              tx_byte_q <= hex_char(s_frame_q[95:92]);
              s_frame_q <= {s_frame_q[91:0], 4'h0};
            end
            if (s_idx_q == 5'd25) begin
              s_state_q <= S_FIN;
            end else begin
              s_idx_q   <= s_idx_q + 5'd1;
              s_state_q <= S_GAP;
            end
          end
        end
        S_GAP: s_state_q <= S_SEND;
        S_FIN: begin
          tx_fin_q  <= 1'b1;
          s_state_q <= S_IDLE;
        end
        default: s_state_q <= S_IDLE;
      endcase
    end
  end

  assign tx_byte     = tx_byte_q;
  assign tx_byte_en  = tx_en_q;
  assign tx_finished = tx_fin_q;

endmodule

// File: tb/tb_uart_wb_bridge.sv
// tb_uart_wb_bridge: drives ASCII command frames into uart_wb_bridge, answers
// its Wishbone cycles, and scoreboards the response bytes and bus cycles.
module tb_uart_wb_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_byte_available = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        tx_ready = 1'b1;
  logic [7:0]  tx_byte;
  logic        tx_byte_en;
  logic        tx_finished;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [31:0] wbm_dat_i = 32'h0;
  logic        wbm_ack_i = 1'b0;

  uart_wb_bridge dut (
    .clk               (clk),
    .rst               (rst),
    .rx_byte_available (rx_byte_available),
    .rx_byte           (rx_byte),
    .tx_ready          (tx_ready),
    .tx_byte           (tx_byte),
    .tx_byte_en        (tx_byte_en),
    .tx_finished       (tx_finished),
    .wbm_cyc_o         (wbm_cyc_o),
    .wbm_stb_o         (wbm_stb_o),
    .wbm_we_o          (wbm_we_o),
    .wbm_sel_o         (wbm_sel_o),
    .wbm_adr_o         (wbm_adr_o),
    .wbm_dat_o         (wbm_dat_o),
    .wbm_dat_i         (wbm_dat_i),
    .wbm_ack_i         (wbm_ack_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic        chk_dat;
    int          len;
  } bus_t;

  bus_t       bus_q[$];
  logic [7:0] exp_q[$];

  int n_checks  = 0;
  int n_fail    = 0;
  int fin_count = 0;
  int exp_fin   = 0;
  int en_during = 0;
  int ack_delay = 0;
  int cyc_cnt   = 0;
  int last_en   = 0;
  int age       = 0;
  bit pace_chk  = 1'b1;
  bit prev_lf   = 1'b0;
  bus_t        cur;
  logic [37:0] cap_ctl;
  logic [31:0] cap_dat;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Expected response bytes for one frame.
  function automatic void push_resp(input logic [31:0] st, input logic [31:0] ad,
                                    input logic [31:0] da);
    logic [95:0] w;
    logic [3:0]  nib;
    string       hx;
    hx = "0123456789ABCDEF";
    w  = {st, ad, da};
    exp_q.push_back(8'h53);
    for (int i = 0; i < 24; i++) begin
      nib = w[95 - 4*i -: 4];
      exp_q.push_back(hx[int'(nib)]);
    end
    exp_q.push_back(8'h0A);
    exp_fin++;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int hold);
    rx_byte           = b;
    rx_byte_available = 1'b1;
    repeat (hold) @(negedge clk);
    rx_byte_available = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_str(input string s, input int hold);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], hold);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || fin_count != exp_fin || wbm_cyc_o) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 64'(n < 3000), 64'd1);
    repeat (4) @(negedge clk);
    check({tag, "_fin"}, 64'(fin_count), 64'(exp_fin));
    check({tag, "_bus_left"}, 64'(bus_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_byte"}, 64'(tx_byte), 64'd0);
    check({tag, "_tx_en"}, 64'(tx_byte_en), 64'd0);
    check({tag, "_tx_fin"}, 64'(tx_finished), 64'd0);
    check({tag, "_cyc_stb_we"}, 64'({wbm_cyc_o, wbm_stb_o, wbm_we_o}), 64'd0);
    check({tag, "_sel"}, 64'(wbm_sel_o), 64'd0);
    check({tag, "_adr"}, 64'(wbm_adr_o), 64'd0);
    check({tag, "_dat"}, 64'(wbm_dat_o), 64'd0);
  endtask

  // Monitor and Wishbone responder, both sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc_cnt++;
      if (!rst) begin
        age       = 0;
        wbm_ack_i = 1'b0;
        prev_lf   = 1'b0;
        continue;
      end
      if (tx_finished) begin
        fin_count++;
        check("fin_after_lf", 64'(prev_lf), 64'd1);
      end
      prev_lf = 1'b0;
      if (tx_byte_en) begin
        logic [7:0] e;
        en_during++;
        check("tx_byte_pending", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          if (pace_chk && e != 8'h53) check("tx_pace", 64'(cyc_cnt - last_en), 64'd2);
          check("tx_byte", 64'(tx_byte), 64'(e));
        end
        last_en = cyc_cnt;
        prev_lf = (tx_byte == 8'h0A);
      end
      if (wbm_cyc_o) begin
        if (age == 0) begin
          check("bus_expected", 64'(bus_q.size() != 0), 64'd1);
          if (bus_q.size() != 0) begin
            cur = bus_q.pop_front();
            check("bus_we", 64'(wbm_we_o), 64'(cur.we));
            check("bus_adr", 64'(wbm_adr_o), 64'(cur.adr));
            if (cur.chk_dat) check("bus_dat", 64'(wbm_dat_o), 64'(cur.dat));
            check("bus_stb_sel", 64'({wbm_stb_o, wbm_sel_o}), 64'h1F);
          end
          cap_ctl = {wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o};
          cap_dat = wbm_dat_o;
        end else begin
          check("bus_hold_ctl", 64'({wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o}), 64'(cap_ctl));
          check("bus_hold_dat", 64'(wbm_dat_o), 64'(cap_dat));
        end
        age++;
      end else if (age > 0) begin
        check("cyc_len", 64'(age), 64'(cur.len));
        check("stb_drop", 64'(wbm_stb_o), 64'd0);
        age = 0;
      end
      wbm_ack_i = wbm_cyc_o && ack_delay > 0 && age == ack_delay;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Ping: no bus activity, all-ones status.
    push_resp(32'hFFFF_FFFF, 32'h0, 32'h0);
    send_str("L000000000000000000000000", 1);
    wait_done("ping");

    // Write with ack three cycles into the bus cycle.
    ack_delay = 3;
    bus_q.push_back('{1'b1, 32'h1000_0000, 32'h1234_5678, 1'b1, 3});
    push_resp(32'hFFFF_FFFE, 32'h1000_0000, 32'h1234_5678);
    send_str("L000000011000000012345678", 1);
    wait_done("write");

    // Read returning a known word on ack.
    wbm_dat_i = 32'hCAFE_BABE;
    bus_q.push_back('{1'b0, 32'h1000_0004, 32'h0, 1'b0, 3});
    push_resp(32'hFFFF_FFFD, 32'h1000_0004, 32'hCAFE_BABE);
    send_str("L000000021000000400000000", 1);
    wait_done("read");

    // Read with no ack: 256-cycle timeout, zero status and data.
    ack_delay = 0;
    bus_q.push_back('{1'b0, 32'h1000_0004, 32'h0, 1'b0, 256});
    push_resp(32'h0000_0000, 32'h1000_0004, 32'h0);
    send_str("L000000021000000400000000", 1);
    wait_done("timeout");

    // Framing: aborted partial frame, then a ping, each byte held high 3 cycles.
    push_resp(32'hFFFF_FFFF, 32'h1234_5678, 32'h0);
    send_str("\nL00Z", 3);
    send_str("L0000000012345678AAAAAAAA", 3);
    wait_done("framing");

    // Unknown command: no bus cycle, status is the inverted command.
    push_resp(32'hFFFF_FFFA, 32'hDEAD_BEEF, 32'h0);
    send_str("L00000005DEADBEEF11111111", 1);
    wait_done("unknown");

    // Lowercase digits, ack in the first bus cycle.
    ack_delay = 1;
    bus_q.push_back('{1'b1, 32'h0000_00A0, 32'hDEAD_BEEF, 1'b1, 1});
    push_resp(32'hFFFF_FFFE, 32'h0000_00A0, 32'hDEAD_BEEF);
    send_str("L00000001000000a0deadbeef", 1);
    wait_done("lower_write");

    // tx_ready low stalls the serializer.
    pace_chk = 1'b0;
    push_resp(32'hFFFF_FFFF, 32'h0, 32'h0);
    send_str("L000000000000000000000000", 1);
    n = 0;
    while (exp_q.size() > 20 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("stall_reach", 64'(n < 500), 64'd1);
    tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    en_during = 0;
    repeat (30) @(negedge clk);
    check("stall_no_tx", 64'(en_during), 64'd0);
    tx_ready = 1'b1;
    wait_done("stall");
    pace_chk = 1'b1;

    // Reset in the middle of a response.
    push_resp(32'hFFFF_FFFF, 32'h0, 32'h0);
    send_str("L000000000000000000000000", 1);
    n = 0;
    while (exp_q.size() > 17 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("midreset_reach", 64'(n < 500), 64'd1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    exp_fin--;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (60) @(negedge clk);
    check("midreset_no_fin", 64'(fin_count), 64'(exp_fin));

    // Normal operation afterwards.
    push_resp(32'hFFFF_FFFF, 32'h0000_0042, 32'h0);
    send_str("L000000000000004200000000", 1);
    wait_done("post_reset_ping");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
